uart_mmio: RTL and testbench
============================

// Module: uart_mmio
// PURPOSE
//  Memory-mapped UART peripheral on the CPU data bus, alongside LED/switch/tube I/O.
//  Serialises CPU-written bytes onto uart_tx and deserialises uart_rx into a readable register.
//  Drives irq into the CPU control unit (exception vector 0x80000008) on TX-done/RX-valid.
// PARAMETERS
//  CLK_HZ   50_000_000  frequency of clk in Hz
//  BAUD     9600        line rate; DIV = CLK_HZ/BAUD clk cycles per bit (integer, >=4)
//  BASE     32'h40000018  address of UART_TXD; RXD = BASE+4, CON = BASE+8
// PORTS
//  clk      in   1   CPU clock; all state on posedge
//  reset    in   1   asynchronous, active-high
//  addr     in   32  byte address from ALU result
//  wdata    in   32  store data (rt)
//  we       in   1   MemWrite
//  re       in   1   MemRead
//  rdata    out  32  combinational read data; 0 when unselected
//  uart_rx  in   1   serial input, asynchronous to clk
//  uart_tx  out  1   serial output, idle high
//  irq      out  1   level interrupt request
// BEHAVIOUR
//  Reset: uart_tx=1, irq=0, rdata=0, all registers/flags 0, both FSMs idle.
//  Registers (word aligned; addr[1:0] ignored; no match -> rdata=0, writes ignored):
//   TXD  W: wdata[7:0] latched, TX starts next cycle if !TX_BUSY; ignored if busy. R: last byte accepted.
//   RXD  R: {24'b0, rx_byte}; a read (re & sel) clears RX_VALID at that clock edge.
//   CON  R: {25'b0, FRAME_ERR[6], OVERRUN[5], TX_BUSY[4], RX_VALID[3], TX_DONE[2], RX_IE[1], TX_IE[0]}
//        W: wdata[1:0] -> IE bits; bits 6:2 read-only. Read of CON clears TX_DONE, OVERRUN, FRAME_ERR.
//  irq = (TX_DONE & TX_IE) | (RX_VALID & RX_IE), registered-flag driven, no extra latency.
//  TX FSM: IDLE -> START (tx=0, DIV cycles) -> DATA (8 bits LSB first, DIV each) -> STOP (tx=1, DIV)
//   -> IDLE; TX_BUSY=1 from accepting edge through end of STOP; TX_DONE set on STOP end.
//  RX: 2-flop synchroniser on uart_rx. FSM IDLE -> START on synced falling edge; re-sample at
//   DIV/2: if 1, false start -> IDLE. DATA: sample every DIV, 8 bits LSB first. STOP: sample at DIV;
//   1 -> rx_byte updated, RX_VALID=1 (OVERRUN=1 if RX_VALID already set; data overwritten);
//   0 -> byte discarded, FRAME_ERR=1. Returns to IDLE after stop sample (no wait for full bit).
//  Simultaneous events (same edge):
//   - byte completes while CPU reads RXD: set wins, RX_VALID stays 1, new byte visible next read.
//   - TX_DONE set while CPU reads CON: set wins.
//   - TXD write on edge TX_BUSY falls: ignored (busy sampled pre-edge).
//   - TXD and CON writes cannot coincide (single bus).
//  Reset mid-frame: both FSMs abort immediately; uart_tx forced 1; partial byte lost.
//  Bit counters: bit-time counter 0..DIV-1, width $clog2(DIV); bit index 0..7, 3 bits, wraps.
// STRUCTURE
//  uart_defs.vh (shared include): register offsets, CON bit positions, TX/RX state encodings.
//  Sub-module uart_rx_core: synchroniser + RX FSM; outputs byte, done pulse, frame_err pulse.
//  TX FSM, register file, address decode, irq logic inline in uart_mmio.
// TESTING  (bench: CLK_HZ=16, BAUD=1 -> DIV=16)
//  Reset mid-TX frame -> uart_tx=1 next cycle, CON reads 0x00, irq=0.
//  sw 0x55 to TXD -> uart_tx low 16 clk, then 1,0,1,0,1,0,1,0 x16 clk each, high 16; CON bit2=1 after.
//  Drive 0xA3 on uart_rx with stop=1, RX_IE=1 -> RXD reads 0xA3, irq=1; lw RXD -> RX_VALID=0, irq=0.
//  Two frames 0x11, 0x22 without reading -> RXD=0x22, CON bit5=1; read CON -> bit5 cleared.
//  Frame with stop=0 -> RX_VALID unchanged, CON bit6=1; 6-clk low glitch on uart_rx -> no frame.
//  Write TXD 0x41 then 0x42 while busy -> only 0x41 on line; TXD reads 0x41; read addr 0x40000030 -> 0.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared UART register offsets, CON bit positions and FSM encodings
package uart_mmio_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0;
  localparam logic [31:0] OFF_RXD = 32'h4;
  localparam logic [31:0] OFF_CON = 32'h8;

  localparam int CON_TX_IE     = 0;
  localparam int CON_RX_IE     = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_OVERRUN   = 5;
  localparam int CON_FRAME_ERR = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_mmio_rx_core.sv
// rtl/uart_mmio_rx_core.sv - uart_rx synchroniser and receive FSM with mid-bit sampling
module uart_mmio_rx_core
  import uart_mmio_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       done,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);

  logic [1:0]       sync;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  rx_state_t        state;

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx};
  end

  assign rx_s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      data      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      rx_prev   <= 1'b1;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      rx_prev   <= rx_s;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            data <= {rx_s, data[7:1]};
            idx  <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) done <= 1'b1;
            else      frame_err <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART: TXD/RXD/CON registers, TX FSM and level irq
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          CLK_HZ = 50_000_000,
  parameter int          BAUD   = 9600,
  parameter logic [31:0] BASE   = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [31:0] TXD_ADDR = BASE + OFF_TXD;
  localparam logic [31:0] RXD_ADDR = BASE + OFF_RXD;
  localparam logic [31:0] CON_ADDR = BASE + OFF_CON;

  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic tx_ie, rx_ie, tx_done, rx_valid, overrun, frame_err, tx_busy;
  logic [7:0] txd_reg, rx_byte, rx_data;
  logic rx_done, rx_ferr;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0] tx_idx;
  tx_state_t tx_state;
  logic [31:0] con_word;
  wire unused_ok = &{1'b0, wdata[31:8], addr[1:0]};

  assign sel_txd = (addr[31:2] == TXD_ADDR[31:2]);
  assign sel_rxd = (addr[31:2] == RXD_ADDR[31:2]);
  assign sel_con = (addr[31:2] == CON_ADDR[31:2]);
  assign wr_txd  = we & sel_txd;
  assign wr_con  = we & sel_con;
  assign rd_rxd  = re & sel_rxd;
  assign rd_con  = re & sel_con;
  assign tx_busy = (tx_state != TX_IDLE);

  uart_mmio_rx_core #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .data      (rx_data),
    .done      (rx_done),
    .frame_err (rx_ferr)
  );

  // TXD writes are only looked at in IDLE, so a write on the edge busy falls is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      txd_reg  <= '0;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      if (rd_con) tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (wr_txd) begin
            txd_reg  <= wdata[7:0];
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_tx  <= txd_reg[0];
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + 3'd1;
            if (tx_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else uart_tx <= txd_reg[tx_idx + 3'd1];
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_done  <= 1'b1;
            tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Clears come first so a same-edge set from the receiver wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ie     <= 1'b0;
      rx_ie     <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= '0;
    end else begin
      if (wr_con) {rx_ie, tx_ie} <= wdata[1:0];
      if (rd_con) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (rd_rxd) rx_valid <= 1'b0;
      if (rx_done) begin
        rx_byte  <= rx_data;
        rx_valid <= 1'b1;
        if (rx_valid) overrun <= 1'b1;
      end
      if (rx_ferr) frame_err <= 1'b1;
    end
  end

  always_comb begin
    con_word = '0;
    con_word[CON_TX_IE]     = tx_ie;
    con_word[CON_RX_IE]     = rx_ie;
    con_word[CON_TX_DONE]   = tx_done;
    con_word[CON_RX_VALID]  = rx_valid;
    con_word[CON_TX_BUSY]   = tx_busy;
    con_word[CON_OVERRUN]   = overrun;
    con_word[CON_FRAME_ERR] = frame_err;
    rdata = '0;
    if (sel_txd)      rdata = {24'b0, txd_reg};
    else if (sel_rxd) rdata = {24'b0, rx_byte};
    else if (sel_con) rdata = con_word;
  end

  assign irq = (tx_done & tx_ie) | (rx_valid & rx_ie);

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - scoreboard bench for uart_mmio at DIV=16
module tb_uart_mmio;

  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] RXD = 32'h4000001C;
  localparam logic [31:0] CON = 32'h40000020;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        uart_rx;
  logic        uart_tx;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_data_q[$];
  logic        exp_irq_q[$];
  string       exp_name_q[$];
  logic [7:0]  tx_q[$];

  bit         tx_mon_en = 1'b1;
  bit         end_chk   = 1'b0;
  bit         end_done  = 1'b0;
  bit         cap_on    = 1'b0;
  int         cap_k     = 0;
  int         cap_err   = 0;
  logic [7:0] cap_byte  = 8'h00;
  logic       tx_prev   = 1'b1;

  uart_mmio #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int idx;
    idx = k / 16;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx - 1];
  endfunction

  // Monitor: checks bus reads against the scoreboard and decodes every TX frame.
  always @(negedge clk) begin
    if (reset) begin
      tests = tests + 2;
      if (uart_tx !== 1'b1) begin
        fails++;
        $display("FAIL reset_tx: got %b expected 1", uart_tx);
      end
      if (irq !== 1'b0) begin
        fails++;
        $display("FAIL reset_irq: got %b expected 0", irq);
      end
      cap_on  = 1'b0;
      tx_prev = 1'b1;
    end else begin
      if (re) begin
        if (exp_data_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_orphan: read of %h with no expectation", addr);
        end else begin
          logic [31:0] ed;
          logic        ei;
          string       nm;
          ed = exp_data_q.pop_front();
          ei = exp_irq_q.pop_front();
          nm = exp_name_q.pop_front();
          tests = tests + 2;
          if (rdata !== ed) begin
            fails++;
            $display("FAIL %s: rdata got %h expected %h", nm, rdata, ed);
          end
          if (irq !== ei) begin
            fails++;
            $display("FAIL %s_irq: irq got %b expected %b", nm, irq, ei);
          end
        end
      end
      if (cap_on) begin
        cap_k++;
        if (uart_tx !== frame_bit(cap_byte, cap_k)) cap_err++;
        if (cap_k == 159) begin
          cap_on = 1'b0;
          tests++;
          if (cap_err != 0) begin
            fails++;
            $display("FAIL tx_wave: byte %h had %0d wrong samples, expected 0", cap_byte, cap_err);
          end
        end
      end else if (tx_mon_en && tx_prev && !uart_tx) begin
        if (tx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_orphan: got start bit, expected no frame");
        end else begin
          cap_byte = tx_q.pop_front();
          cap_on   = 1'b1;
          cap_k    = 0;
          cap_err  = (uart_tx !== frame_bit(cap_byte, 0)) ? 1 : 0;
        end
      end
      tx_prev = uart_tx;
      if (end_chk && !end_done) begin
        end_done = 1'b1;
        tests++;
        if (tx_q.size() != 0 || cap_on) begin
          fails++;
          $display("FAIL tx_pending: got %0d frames outstanding, expected 0", tx_q.size());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick(1);
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] d, input logic i, input string nm);
    exp_data_q.push_back(d);
    exp_irq_q.push_back(i);
    exp_name_q.push_back(nm);
    addr = a;
    re   = 1'b1;
    tick(1);
    re   = 1'b0;
    addr = '0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(16);
    end
    uart_rx = stop;
    tick(16);
    uart_rx = 1'b1;
    tick(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    addr    = '0;
    wdata   = '0;
    we      = 1'b0;
    re      = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    reset = 1'b0;
    bus_read(CON, 32'h00, 1'b0, "con_after_reset");

    // TX 0x55 with TX_IE
    bus_write(CON, 32'h1);
    tx_q.push_back(8'h55);
    bus_write(TXD, 32'h55);
    bus_read(CON, 32'h11, 1'b0, "con_tx_busy");
    tick(170);
    bus_read(CON, 32'h05, 1'b1, "con_tx_done");
    bus_read(CON, 32'h01, 1'b0, "con_tx_done_clr");

    // RX 0xA3 with RX_IE
    bus_write(CON, 32'h2);
    send_rx(8'hA3, 1'b1);
    bus_read(CON, 32'h0A, 1'b1, "con_rx_valid");
    bus_read(RXD, 32'hA3, 1'b1, "rxd_a3");
    bus_read(CON, 32'h02, 1'b0, "con_rx_cleared");

    // Overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(CON, 32'h2A, 1'b1, "con_overrun");
    bus_read(RXD, 32'h22, 1'b1, "rxd_22");
    bus_read(CON, 32'h02, 1'b0, "con_overrun_clr");

    // Framing error
    send_rx(8'h5C, 1'b0);
    bus_read(CON, 32'h42, 1'b0, "con_frame_err");
    bus_read(CON, 32'h02, 1'b0, "con_frame_err_clr");
    bus_read(RXD, 32'h22, 1'b0, "rxd_kept");

    // 6-clock glitch is a false start
    uart_rx = 1'b0;
    tick(6);
    uart_rx = 1'b1;
    tick(40);
    bus_read(CON, 32'h02, 1'b0, "con_glitch");

    // Write while busy is dropped
    tx_q.push_back(8'h41);
    bus_write(TXD, 32'h41);
    bus_write(TXD, 32'h42);
    bus_read(TXD, 32'h41, 1'b0, "txd_busy");
    tick(180);
    bus_read(TXD, 32'h41, 1'b0, "txd_last");
    bus_read(CON, 32'h06, 1'b0, "con_done_no_ie");
    bus_write(CON, 32'hFFFF_FFFF);
    bus_read(CON, 32'h03, 1'b0, "con_ie_only");
    bus_read(32'h4000_0030, 32'h0, 1'b0, "unmapped");

    // Reset mid-frame with a pending rx irq
    send_rx(8'h77, 1'b1);
    bus_read(CON, 32'h0B, 1'b1, "con_pre_reset");
    tx_mon_en = 1'b0;
    bus_write(TXD, 32'h5A);
    tick(10);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    bus_read(CON, 32'h00, 1'b0, "con_post_reset");
    bus_read(RXD, 32'h00, 1'b0, "rxd_post_reset");
    bus_read(TXD, 32'h00, 1'b0, "txd_post_reset");

    end_chk = 1'b1;
    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
